phase_timer: RTL and testbench
==============================

# phase_timer

Parametrised countdown timer for washing-machine cycle phases (wash, rinse, spin). Loads a per-phase duration at start, counts it down in whole seconds derived from `CLOCK`, and supports pause/resume, abort and a held done flag with acknowledge. Sits between the cycle controller FSM, which issues start, pause, abort and ack, and the BCD/7-segment display path, which reads `value`. All outputs are driven at all times; there is no tri-state output.

## Interface

- `WIDTH`, 8: width of `duration` and `value`, in seconds.
- `CLOCK_HZ`, 50000000: `CLOCK` cycles per one-second tick. Minimum 2.
- `DEFAULT_DURATION`, 5: seconds loaded when `duration` is 0 at start. Must be nonzero and fit in `WIDTH` bits.
- `WARN_LEVEL`, 2: warn threshold in seconds. Used only when `PHASE_TIMER_WARN_EN` is defined.

- `CLOCK` in 1: system clock. All logic updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level input; loads the duration and begins a run.
- `duration` in WIDTH: phase length in seconds, sampled only on an accepted start.
- `pause` in 1: level input; freezes the countdown while high.
- `abort` in 1: cancels the run and returns the block to IDLE.
- `ack` in 1: clears `done`.
- `value` out WIDTH: remaining seconds.
- `active` out 1: high in RUN.
- `paused` out 1: high in HOLD.
- `done` out 1: high in DONE, held until acknowledged.
- `tick` out 1: one-cycle pulse on each decrement of `value`.
- `warn` out 1: near-end warning (see Configuration).

## Operation

- States:
  - IDLE (encoding 0)
  - RUN
  - HOLD
  - DONE
- Prescaler: counter of width clog2(CLOCK_HZ).
  - Increments only in RUN.
  - On reaching CLOCK_HZ-1 it wraps to 0, `tick`=1 and `value` decrements.
- Priority each cycle: `reset` > `abort` > state transition logic.
- Transitions:
  - IDLE, `start`=1 → RUN. `value` loads `duration`, or `DEFAULT_DURATION` if `duration`=0. Prescaler clears.
  - RUN, `pause`=1 → HOLD. The prescaler keeps its count and does not increment.
  - HOLD, `pause`=0 → RUN. Counting resumes from the frozen prescaler value.
  - RUN, tick with `value`=1 → DONE. `value` becomes 0 and `done`=1 on the same edge.
  - DONE, `ack`=1 → IDLE. `done`=0 and `value` stays 0.
  - DONE, `start`=1 → RUN with a fresh load. This takes precedence over a simultaneous `ack`.
  - Any state, `abort`=1 → IDLE. `value`=0, prescaler=0, `done`=0. No `done` is produced.
- `start` is ignored in RUN and HOLD. A new duration is never accepted mid-run.
- In RUN, `pause` is sampled before the tick. If `pause` rises on the tick cycle, the block enters HOLD and no decrement occurs.
- If `start` and `pause` are both high in IDLE, the block enters RUN. `pause` takes effect on the next cycle.
- `value` never underflows; 0 is reached only through the DONE transition or via abort/reset.

## Timing

- Reset values:
  - state=IDLE
  - `value`=0
  - prescaler=0
  - `active`=0, `paused`=0, `done`=0, `tick`=0, `warn`=0
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Start latency: `start` is sampled at edge N. `active`=1 and `value`=load value are visible after edge N.
- Run length with no pause: exactly load×CLOCK_HZ cycles in RUN, from the start edge to the edge that asserts `done`.
- Pause latency: one cycle in both directions. HOLD cycles are excluded from the run length.
- `tick` is high for exactly one cycle per decrement, including the final 1→0 decrement.
- A mid-run `reset` or `abort` takes effect on that same edge.

## Configuration

- `PHASE_TIMER_WARN_EN` defined:
  - `warn`=1 while in RUN or HOLD and 0 < `value` ≤ `WARN_LEVEL`.
  - `warn`=0 in IDLE and DONE.
  - `warn` is registered and updates on the same edge as `value`.
- `PHASE_TIMER_WARN_EN` not defined:
  - `warn` port is present and tied to 0.
  - `WARN_LEVEL` is unused and no comparator is built.

## Test plan

All scenarios use `CLOCK_HZ`=4 and `WIDTH`=8.

- Reset then `start`, `duration`=3 → `value` 3,2,1,0 at 4-cycle spacing; three `tick` pulses; `done`=1 at cycle 12 after start; `active`=0 once `done`=1.
- `start` with `duration`=0 → `value`=5 (`DEFAULT_DURATION`); `done` after 20 RUN cycles.
- `duration`=2, `pause` high for 7 cycles starting at cycle 2 → `paused`=1 for those cycles; `value` frozen; `done` at cycle 15 (8+7).
- `done` held, then `ack`=1 → IDLE after one edge; `done` held, then `start`+`ack` with `duration`=1 → RUN, `value`=1.
- `abort` mid-run at `value`=2, and `reset` mid-run in HOLD → IDLE, `value`=0, `done` never asserted; a `start` in RUN is ignored and `value` continues unchanged.
- With `PHASE_TIMER_WARN_EN` defined, `duration`=4 → `warn` rises on the edge where `value`=2 and falls when `done`=1; with it undefined, `warn` stays 0 throughout.

Source files
------------

// File: rtl/phase_timer.sv
// Countdown timer for washing-machine phases: whole-second ticks from a prescaler, pause/resume, abort, held done.
// Optional near-end warning output is built only when PHASE_TIMER_WARN_EN is defined.
module phase_timer #(
  parameter int WIDTH            = 8,
  parameter int CLOCK_HZ         = 50000000,
  parameter int DEFAULT_DURATION = 5,
  parameter int WARN_LEVEL       = 2
) (
  input  logic             CLOCK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             active,
  output logic             paused,
  output logic             done,
  output logic             tick,
  output logic             warn
);

  localparam int              PW        = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLOCK_HZ - 1);
  localparam logic [WIDTH-1:0] DEF_LOAD = WIDTH'(DEFAULT_DURATION);

  generate
    if (CLOCK_HZ < 2 || DEFAULT_DURATION < 1 || (DEFAULT_DURATION >> WIDTH) != 0 || WARN_LEVEL < 0)
    begin : g_bad_params
      $error("phase_timer: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] value_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic             tick_nx;

  always_comb begin
    state_nx = state;
    value_nx = value;
    presc_nx = presc;
    tick_nx  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      value_nx = '0;
      presc_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            value_nx = (duration == '0) ? DEF_LOAD : duration;
            presc_nx = '0;
          end
        end
        RUN, HOLD: begin
          // Pause wins over the tick; releasing pause resumes counting on that same edge.
          if (pause) begin
            state_nx = HOLD;
          end else begin
            state_nx = RUN;
            if (presc == PRESC_MAX) begin
              presc_nx = '0;
              tick_nx  = 1'b1;
              if (value <= WIDTH'(1)) begin
                value_nx = '0;
                state_nx = DONE;
              end else begin
                value_nx = value - 1'b1;
              end
            end else begin
              presc_nx = presc + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_nx = RUN;
            value_nx = (duration == '0) ? DEF_LOAD : duration;
            presc_nx = '0;
          end else if (ack) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state  <= IDLE;
      value  <= '0;
      presc  <= '0;
      tick   <= 1'b0;
      active <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      value  <= value_nx;
      presc  <= presc_nx;
      tick   <= tick_nx;
      active <= (state_nx == RUN);
      paused <= (state_nx == HOLD);
      done   <= (state_nx == DONE);
    end
  end

`ifdef PHASE_TIMER_WARN_EN
  localparam logic [WIDTH-1:0] WARN_THR = WIDTH'(WARN_LEVEL);
  logic warn_nx;

  assign warn_nx = ((state_nx == RUN) || (state_nx == HOLD)) &&
                   (value_nx != '0) && (value_nx <= WARN_THR);

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      warn <= 1'b0;
    end else begin
      warn <= warn_nx;
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer at CLOCK_HZ=4: stimulus queues expected events, a monitor checks them.
module tb_phase_timer;

  logic       CLOCK = 1'b0;
  logic       reset, start, pause, abort, ack, probe;
  logic [7:0] duration;
  logic [7:0] value;
  logic       active, paused, done, tick, warn;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_id  = 0;

  typedef struct {
    int         id;
    int         cyc;
    logic [7:0] v;
    logic       a, p, d, t, w;
  } exp_t;

  exp_t q[$];

  phase_timer #(.WIDTH(8), .CLOCK_HZ(4), .DEFAULT_DURATION(5), .WARN_LEVEL(2)) dut (
    .CLOCK(CLOCK), .reset(reset), .start(start), .duration(duration), .pause(pause),
    .abort(abort), .ack(ack), .value(value), .active(active), .paused(paused),
    .done(done), .tick(tick), .warn(warn)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] v, input logic a, input logic p,
                      input logic d, input logic t);
    exp_t e;
    e.id = n_id; e.cyc = c; e.v = v; e.a = a; e.p = p; e.d = d; e.t = t;
`ifdef PHASE_TIMER_WARN_EN
    e.w = (a | p) && (v != 8'd0) && (v <= 8'd2);
`else
    e.w = 1'b0;
`endif
    n_id++;
    q.push_back(e);
  endtask

  // Call at a negedge with inputs already set; checks the state after the next edge.
  task automatic probe_now(input logic [7:0] v, input logic a, input logic p, input logic d);
    probe = 1'b1;
    push(cyc + 1, v, a, p, d, 1'b0);
    @(negedge CLOCK);
    probe = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] dur, input logic [7:0] load, input logic with_ack,
                           output int s);
    @(negedge CLOCK);
    duration = dur; start = 1'b1; ack = with_ack;
    s = cyc + 1;
    probe_now(load, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t - 1) @(negedge CLOCK);
  endtask

  // Monitor: any tick, rising done or probe is an output event to be matched.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(posedge CLOCK);
      #1;
      if (tick === 1'b1 || (done === 1'b1 && !done_q) || probe) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d: got v=%0d a=%b p=%b d=%b t=%b, required no event",
                   cyc, value, active, paused, done, tick);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || value !== e.v || active !== e.a || paused !== e.p ||
              done !== e.d || tick !== e.t || warn !== e.w) begin
            n_bad++;
            $display("FAIL chk%0d: got cyc=%0d v=%0d a=%b p=%b d=%b t=%b w=%b, required cyc=%0d v=%0d a=%b p=%b d=%b t=%b w=%b",
                     e.id, cyc, value, active, paused, done, tick, warn,
                     e.cyc, e.v, e.a, e.p, e.d, e.t, e.w);
          end
        end
      end
      done_q = (done === 1'b1);
    end
  end

  initial begin
    int s, s2;
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; ack = 1'b0; probe = 1'b0;
    duration = 8'd0;

    // reset state
    @(negedge CLOCK);
    reset = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);

    // duration 3: ticks every 4 cycles, done 12 cycles after start, then ack
    start_run(8'd3, 8'd3, 1'b0, s);
    push(s + 4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    push(s + 8, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(s + 12, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_to(s + 14);
    ack = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);

    // duration 0 loads the default of 5
    start_run(8'd0, 8'd5, 1'b0, s);
    for (int k = 1; k <= 5; k++)
      push(s + 4 * k, 8'(5 - k), (k != 5), 1'b0, (k == 5), 1'b1);
    wait_to(s + 22);
    ack = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);

    // duration 2 with pause sampled high on 7 edges: done at 15
    start_run(8'd2, 8'd2, 1'b0, s);
    wait_to(s + 2);
    pause = 1'b1;
    probe_now(8'd2, 1'b0, 1'b1, 1'b0);
    wait_to(s + 9);
    pause = 1'b0;
    probe_now(8'd2, 1'b1, 1'b0, 1'b0);
    push(s + 11, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(s + 15, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // done held, then start with simultaneous ack reloads
    wait_to(s + 18);
    start_run(8'd1, 8'd1, 1'b1, s2);
    push(s2 + 4, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_to(s2 + 6);
    ack = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);

    // start in RUN ignored, then abort at value 2
    start_run(8'd3, 8'd3, 1'b0, s);
    wait_to(s + 2);
    start = 1'b1; duration = 8'd9;
    probe_now(8'd3, 1'b1, 1'b0, 1'b0);
    push(s + 4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_to(s + 6);
    abort = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);
    wait_to(s + 30);

    // reset while in HOLD
    start_run(8'd3, 8'd3, 1'b0, s);
    wait_to(s + 2);
    pause = 1'b1;
    probe_now(8'd3, 1'b0, 1'b1, 1'b0);
    wait_to(s + 5);
    reset = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);
    pause = 1'b0;
    wait_to(s + 30);

    // duration 4: warn (when built) follows value 2 and 1
    start_run(8'd4, 8'd4, 1'b0, s);
    for (int k = 1; k <= 4; k++)
      push(s + 4 * k, 8'(4 - k), (k != 4), 1'b0, (k == 4), 1'b1);
    wait_to(s + 18);
    ack = 1'b1;
    probe_now(8'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLOCK);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d still pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
